sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO. It is the same-clock successor to the team's dual-clock FIFO and is used wherever producer and consumer share one clock domain, so no gray-code synchronisers are needed.
It adds several features: a selectable standard or first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags with a clear input.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH words
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AFULL_THRESH, DEPTH-2, almost_full asserts when count >= AFULL_THRESH (legal range 1..DEPTH)
AEMPTY_THRESH, 1, almost_empty asserts when count <= AEMPTY_THRESH (legal range 0..DEPTH-1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
din  input  DATA_WIDTH  write data
rd_en  input  1  read request (FWFT: acknowledge/pop of the presented word)
dout  output  DATA_WIDTH  read data, registered
full  output  1  no write is accepted
empty  output  1  standard mode: count==0; FWFT mode: dout is not valid
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  ADDR_WIDTH+1  words written and not yet popped (0..DEPTH)
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty
clr_err  input  1  synchronous clear of overflow and underflow

Behaviour:
- Reset (rst_n low, asynchronous): pointers=0, count=0, dout=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Memory contents are not cleared. Reset asserted mid-operation discards all words; the next write after release becomes the head.
- Pointers are ADDR_WIDTH+1 bits binary. The memory index is the low ADDR_WIDTH bits, with natural wrap at DEPTH.
- Write acceptance: wr_en && !full, evaluated against the flags before the edge. The accepted word is stored at wr_ptr and wr_ptr increments.
- Read acceptance: rd_en && !empty, evaluated against the flags before the edge.
- count: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted.
- full = (count==DEPTH).
- almost_full and almost_empty are combinational compares on the count register, so they update in the same cycle as count.
- Standard mode:
  - An accepted read loads dout from mem[rd_ptr] at that edge, giving 1-cycle latency. dout holds its value otherwise.
  - A word written at edge E is readable with rd_en sampled at E+1, since empty drops after E.
- FWFT mode:
  - An internal output stage holds the head word, and dout shows it whenever empty=0.
  - When the output stage is invalid and the memory is non-empty, the head is prefetched. A word written into an empty FIFO at edge E appears on dout with empty=0 after edge E+1.
  - rd_en with empty=0 pops the head. The next word is presented after the same edge if available; otherwise empty=1 and dout holds its last value.
  - count includes the word in the output stage. Total capacity is DEPTH in both modes.
- Simultaneous write and read:
  - When full: the read is accepted and the write is rejected, with overflow set; count becomes DEPTH-1.
  - When empty: the write is accepted and the read is rejected, with underflow set; count becomes 1.
  - Otherwise both are accepted and count is unchanged.
- Error flags:
  - overflow sets on wr_en && full.
  - underflow sets on rd_en && empty.
  - clr_err clears both flags on the next edge. A new set event in the same cycle takes priority over clr_err.

Decomposition:
- Shared package fifo_pkg:
  - mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1
  - default width/depth constants
  - a clog2 helper function, shared with the dual-clock FIFO
- One natural sub-module, sync_fifo_mem:
  - simple dual-port RAM, DATA_WIDTH x DEPTH
  - one write port and one registered read port with a read enable
  - used in both modes; the FWFT output stage stays in the top level.

Test Plan:
1. Reset then idle, FWFT=0, DEPTH=16 -> empty=1, full=0, count=0, almost_empty=1, dout=0, flags=0.
2. Write 0x01..0x10 (16 words), then a 17th write 0xAA -> full=1 after 16th, count=16, overflow=1, 0xAA dropped. Read 16 words -> dout sequence 0x01..0x10 at 1-cycle latency; empty=1 after last; one extra rd_en -> underflow=1; clr_err -> both flags 0.
3. Thresholds AFULL_THRESH=14, AEMPTY_THRESH=1: write 14 words -> almost_full rises exactly when count=14; almost_empty falls when count=2.
4. Simultaneous wr_en/rd_en: at count=16 -> count=15, overflow=1. At count=0 -> count=1, underflow=1. At count=5 for 20 cycles of streaming -> count stays 5, data order preserved across pointer wrap.
5. FWFT=1: write 0x3C at edge E into empty FIFO -> dout=0x3C, empty=0 after E+1. Pop with rd_en -> next word presented after the same edge, or empty=1 if none.
6. Assert rst_n low mid-stream at count=7 -> all outputs return to reset values immediately. After release, write 0x55 then read -> dout=0x55, no stale data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors, default geometry and a
// constant-friendly ceil(log2) helper used by both the sync and dual-clock FIFOs.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Only the read register is reset; array contents survive reset.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// occupancy count, almost-full/empty thresholds and sticky error flags.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count_r;
  logic                wr_acc;
  logic                rd_acc;
  logic                mem_rd_en;
  logic                empty_int;

  assign full         = (count_r == DEPTH_C);
  assign empty        = empty_int;
  assign count        = count_r;
  assign almost_full  = (count_r >= AF_C);
  assign almost_empty = (count_r <= AE_C);
  assign wr_acc       = wr_en && !full;
  assign rd_acc       = rd_en && !empty_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (wr_acc)    wr_ptr <= wr_ptr + ONE_C;
      if (mem_rd_en) rd_ptr <= rd_ptr + ONE_C;
      case ({wr_acc, rd_acc})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // A fresh error event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (rd_en && empty_int) underflow <= 1'b1;
      else if (clr_err)       underflow <= 1'b0;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data(din),
    .rd_en  (mem_rd_en),
    .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data(dout)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // The RAM read register doubles as the output stage; out_valid marks
      // whether it holds the head. Prefetch when it is free or being popped.
      logic out_valid;
      logic mem_has_data;

      assign mem_has_data = (wr_ptr != rd_ptr);
      assign mem_rd_en    = mem_has_data && (!out_valid || rd_acc);
      assign empty_int    = !out_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         out_valid <= 1'b0;
        else if (mem_rd_en) out_valid <= 1'b1;
        else if (rd_acc)    out_valid <= 1'b0;
      end
    end else begin : g_std
      assign mem_rd_en = rd_acc;
      assign empty_int = (count_r == '0);
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench: a standard-mode and a FWFT instance, each checked
// against a data queue and a bench-side occupancy model.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       s_wr_en = 0, s_rd_en = 0, s_clr = 0;
  logic [7:0] s_din = 0, s_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [4:0] s_count;

  logic       f_wr_en = 0, f_rd_en = 0, f_clr = 0;
  logic [7:0] f_din = 0, f_dout;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_count;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic [4:0] m_cnt;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0),
                   .AFULL_THRESH(14), .AEMPTY_THRESH(1)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .din(s_din), .rd_en(s_rd_en),
    .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf),
    .clr_err(s_clr));

  sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1),
                   .AFULL_THRESH(14), .AEMPTY_THRESH(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en),
    .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf),
    .clr_err(f_clr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total_cnt++; if (s_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", s_empty); else pass_cnt++;
    total_cnt++; if (s_full !== 1'b0) $display("FAIL reset_full got %b want 0", s_full); else pass_cnt++;
    total_cnt++; if (s_count !== 5'd0) $display("FAIL reset_count got %0d want 0", s_count); else pass_cnt++;
    total_cnt++; if (s_ae !== 1'b1 || s_af !== 1'b0) $display("FAIL reset_almost got ae=%b af=%b want 1/0", s_ae, s_af); else pass_cnt++;
    total_cnt++; if (s_dout !== 8'h00) $display("FAIL reset_dout got %h want 00", s_dout); else pass_cnt++;
    total_cnt++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) $display("FAIL reset_flags got %b%b want 00", s_ovf, s_unf); else pass_cnt++;
    total_cnt++; if (f_empty !== 1'b1 || f_count !== 5'd0) $display("FAIL reset_fwft got empty=%b count=%0d want 1/0", f_empty, f_count); else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    q.delete();
    m_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      s_wr_en = 1; s_din = 8'(i + 1);
      tick();
      q.push_back(8'(i + 1)); m_cnt++;
      total_cnt++; if (s_count !== m_cnt) $display("FAIL fill_count got %0d want %0d", s_count, m_cnt); else pass_cnt++;
      total_cnt++; if (s_af !== (m_cnt >= 14)) $display("FAIL fill_afull at count %0d got %b want %b", m_cnt, s_af, (m_cnt >= 14)); else pass_cnt++;
      total_cnt++; if (s_ae !== (m_cnt <= 1)) $display("FAIL fill_aempty at count %0d got %b want %b", m_cnt, s_ae, (m_cnt <= 1)); else pass_cnt++;
    end
    total_cnt++; if (s_full !== 1'b1) $display("FAIL full_after16 got %b want 1", s_full); else pass_cnt++;
    s_din = 8'hAA;
    tick();
    s_wr_en = 0;
    total_cnt++; if (s_ovf !== 1'b1 || s_count !== 5'd16) $display("FAIL overflow got ovf=%b count=%0d want 1/16", s_ovf, s_count); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      s_rd_en = 1;
      tick();
      exp_d = q.pop_front(); m_cnt--;
      total_cnt++; if (s_dout !== exp_d) $display("FAIL drain_data got %h want %h", s_dout, exp_d); else pass_cnt++;
      total_cnt++; if (s_count !== m_cnt) $display("FAIL drain_count got %0d want %0d", s_count, m_cnt); else pass_cnt++;
      total_cnt++; if (s_af !== (m_cnt >= 14) || s_ae !== (m_cnt <= 1)) $display("FAIL drain_almost at count %0d got af=%b ae=%b", m_cnt, s_af, s_ae); else pass_cnt++;
    end
    total_cnt++; if (s_empty !== 1'b1) $display("FAIL empty_after_drain got %b want 1", s_empty); else pass_cnt++;
    tick();
    s_rd_en = 0;
    total_cnt++; if (s_unf !== 1'b1 || s_dout !== 8'h10) $display("FAIL underflow got unf=%b dout=%h want 1/10", s_unf, s_dout); else pass_cnt++;
    s_clr = 1;
    tick();
    s_clr = 0;
    total_cnt++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) $display("FAIL clr_err got %b%b want 00", s_ovf, s_unf); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    q.delete();
    m_cnt = 0;
    s_wr_en = 1;
    for (int i = 0; i < 16; i++) begin
      s_din = 8'(8'h40 + i);
      tick();
      q.push_back(8'(8'h40 + i)); m_cnt++;
    end
    s_rd_en = 1; s_din = 8'hEE;
    tick();
    exp_d = q.pop_front(); m_cnt--;
    s_wr_en = 0;
    total_cnt++; if (s_count !== 5'd15 || s_ovf !== 1'b1) $display("FAIL simul_full got count=%0d ovf=%b want 15/1", s_count, s_ovf); else pass_cnt++;
    total_cnt++; if (s_dout !== exp_d) $display("FAIL simul_full_data got %h want %h", s_dout, exp_d); else pass_cnt++;
    while (q.size() > 0) begin
      tick();
      exp_d = q.pop_front(); m_cnt--;
      total_cnt++; if (s_dout !== exp_d) $display("FAIL simul_drain got %h want %h", s_dout, exp_d); else pass_cnt++;
    end
    s_rd_en = 0; s_clr = 1;
    tick();
    s_clr = 0;
    s_wr_en = 1; s_rd_en = 1; s_din = 8'h80;
    tick();
    q.push_back(8'h80); m_cnt++;
    s_rd_en = 0;
    total_cnt++; if (s_count !== 5'd1 || s_unf !== 1'b1) $display("FAIL simul_empty got count=%0d unf=%b want 1/1", s_count, s_unf); else pass_cnt++;
    for (int i = 1; i < 5; i++) begin
      s_din = 8'(8'h80 + i);
      tick();
      q.push_back(8'(8'h80 + i)); m_cnt++;
    end
    s_rd_en = 1;
    for (int i = 5; i < 25; i++) begin
      s_din = 8'(8'h80 + i);
      tick();
      q.push_back(8'(8'h80 + i));
      exp_d = q.pop_front();
      total_cnt++; if (s_dout !== exp_d || s_count !== 5'd5) $display("FAIL stream got dout=%h count=%0d want %h/5", s_dout, s_count, exp_d); else pass_cnt++;
    end
    s_wr_en = 0;
    while (q.size() > 0) begin
      tick();
      exp_d = q.pop_front();
      total_cnt++; if (s_dout !== exp_d) $display("FAIL stream_drain got %h want %h", s_dout, exp_d); else pass_cnt++;
    end
    s_rd_en = 0; s_clr = 1;
    tick();
    s_clr = 0;
  endtask

  task automatic test_fwft();
    q.delete();
    f_wr_en = 1; f_din = 8'h3C;
    tick();
    q.push_back(8'h3C);
    f_wr_en = 0;
    total_cnt++; if (f_empty !== 1'b1 || f_count !== 5'd1) $display("FAIL fwft_edgeE got empty=%b count=%0d want 1/1", f_empty, f_count); else pass_cnt++;
    tick();
    total_cnt++; if (f_empty !== 1'b0 || f_dout !== 8'h3C) $display("FAIL fwft_first got empty=%b dout=%h want 0/3c", f_empty, f_dout); else pass_cnt++;
    f_wr_en = 1;
    for (int i = 1; i < 16; i++) begin
      f_din = 8'(8'h60 + i);
      tick();
      q.push_back(8'(8'h60 + i));
    end
    total_cnt++; if (f_full !== 1'b1 || f_count !== 5'd16) $display("FAIL fwft_full got full=%b count=%0d want 1/16", f_full, f_count); else pass_cnt++;
    f_din = 8'hAA;
    tick();
    f_wr_en = 0;
    total_cnt++; if (f_ovf !== 1'b1 || f_count !== 5'd16) $display("FAIL fwft_overflow got ovf=%b count=%0d want 1/16", f_ovf, f_count); else pass_cnt++;
    while (q.size() > 0) begin
      total_cnt++; if (f_empty !== 1'b0 || f_dout !== q[0]) $display("FAIL fwft_head got empty=%b dout=%h want 0/%h", f_empty, f_dout, q[0]); else pass_cnt++;
      exp_d = q.pop_front();
      f_rd_en = 1;
      tick();
      f_rd_en = 0;
      total_cnt++; if (f_count !== 5'(q.size())) $display("FAIL fwft_count got %0d want %0d", f_count, q.size()); else pass_cnt++;
    end
    total_cnt++; if (f_empty !== 1'b1 || f_dout !== exp_d) $display("FAIL fwft_last got empty=%b dout=%h want 1/%h", f_empty, f_dout, exp_d); else pass_cnt++;
    f_rd_en = 1;
    tick();
    f_rd_en = 0;
    total_cnt++; if (f_unf !== 1'b1 || f_count !== 5'd0) $display("FAIL fwft_underflow got unf=%b count=%0d want 1/0", f_unf, f_count); else pass_cnt++;
    f_clr = 1;
    tick();
    f_clr = 0;
    total_cnt++; if (f_ovf !== 1'b0 || f_unf !== 1'b0) $display("FAIL fwft_clr got %b%b want 00", f_ovf, f_unf); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    q.delete();
    s_wr_en = 1;
    for (int i = 0; i < 7; i++) begin
      s_din = 8'(8'hC0 + i);
      tick();
    end
    s_wr_en = 0; s_rd_en = 1;
    tick();
    s_rd_en = 0;
    total_cnt++; if (s_count !== 5'd6 || s_dout !== 8'hC0) $display("FAIL pre_reset got count=%0d dout=%h want 6/c0", s_count, s_dout); else pass_cnt++;
    s_wr_en = 1; s_din = 8'hC7;
    tick();
    s_wr_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (s_count !== 5'd0 || s_empty !== 1'b1 || s_full !== 1'b0) $display("FAIL midreset_state got count=%0d empty=%b full=%b", s_count, s_empty, s_full); else pass_cnt++;
    total_cnt++; if (s_dout !== 8'h00 || s_ae !== 1'b1 || s_af !== 1'b0) $display("FAIL midreset_out got dout=%h ae=%b af=%b", s_dout, s_ae, s_af); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    s_wr_en = 1; s_din = 8'h55;
    tick();
    s_wr_en = 0; s_rd_en = 1;
    tick();
    s_rd_en = 0;
    total_cnt++; if (s_dout !== 8'h55 || s_count !== 5'd0) $display("FAIL post_reset got dout=%h count=%0d want 55/0", s_dout, s_count); else pass_cnt++;
    total_cnt++; if (s_unf !== 1'b0 || s_ovf !== 1'b0) $display("FAIL post_reset_flags got %b%b want 00", s_ovf, s_unf); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_fwft();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
